// File: rtl/alu_frame_sequencer_if.sv
// UART byte handshake between the frame sequencer and the UART pair.
// slave is the sequencer side, master is the UART side.
interface alu_frame_sequencer_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_tx_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  modport slave (
    input  i_rx_data,
    input  i_rx_valid,
    input  i_tx_done,
    output o_tx_data,
    output o_tx_start
  );

  modport master (
    output i_rx_data,
    output i_rx_valid,
    output i_tx_done,
    input  o_tx_data,
    input  o_tx_start
  );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Byte-stream front end for the ALU: 10-byte command frame in,
// 5-byte response frame (result MSB first, zero flag) out.
module alu_frame_sequencer #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_SHAMT     = 5,
  parameter int BITS_OP        = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_frame_sequencer_if.slave  uart,
  output logic [BITS_SIZE-1:0]  o_data_a,
  output logic [BITS_SIZE-1:0]  o_data_b,
  output logic [BITS_SHAMT-1:0] o_alu_shamt,
  output logic                  o_flag_shamt,
  output logic [BITS_OP-1:0]    o_op,
  input  logic [BITS_SIZE-1:0]  i_alu_result,
  input  logic                  i_alu_zero,
  output logic                  o_busy,
  output logic                  o_rx_overrun,
  output logic                  o_frame_error
);

  localparam logic [1:0] RECV    = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] WAIT_TX = 2'd3;

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]           state;
  logic [3:0]           byte_cnt;
  logic [2:0]           tx_idx;
  logic [TW-1:0]        to_cnt;
  logic [BITS_SIZE-1:0] result_reg;
  logic                 zero_reg;
  logic [7:0]           rx;
  logic                 take;
  logic [7:0]           tx_byte;

  assign rx   = uart.i_rx_data;
  assign take = uart.i_rx_valid && (state == RECV);

  // Operand registers: each accepted byte lands in its frame slot.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_data_a     <= '0;
      o_data_b     <= '0;
      o_op         <= '0;
      o_flag_shamt <= 1'b0;
      o_alu_shamt  <= '0;
    end else if (take) begin
      case (byte_cnt)
        4'd0: o_data_a[31:24] <= rx;
        4'd1: o_data_a[23:16] <= rx;
        4'd2: o_data_a[15:8]  <= rx;
        4'd3: o_data_a[7:0]   <= rx;
        4'd4: o_data_b[31:24] <= rx;
        4'd5: o_data_b[23:16] <= rx;
        4'd6: o_data_b[15:8]  <= rx;
        4'd7: o_data_b[7:0]   <= rx;
        4'd8: begin
          o_op         <= rx[BITS_OP-1:0];
          o_flag_shamt <= rx[7];
        end
        4'd9: o_alu_shamt <= rx[BITS_SHAMT-1:0];
        default: ;
      endcase
    end
  end

  // Frame FSM: receive, one settle cycle, then byte-wise response.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= RECV;
      byte_cnt      <= '0;
      tx_idx        <= '0;
      to_cnt        <= '0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      o_rx_overrun  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_frame_error <= 1'b0;
      if (uart.i_rx_valid && state != RECV)
        o_rx_overrun <= 1'b1;
      case (state)
        RECV: begin
          if (uart.i_rx_valid) begin
            to_cnt <= '0;
            if (byte_cnt == 4'd9) begin
              byte_cnt <= '0;
              state    <= EXEC;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (byte_cnt != 4'd0
                       && TIMEOUT_CYCLES != 0) begin
            if (to_cnt == TO_LAST) begin
              byte_cnt      <= '0;
              to_cnt        <= '0;
              o_frame_error <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          result_reg <= i_alu_result;
          zero_reg   <= i_alu_zero;
          tx_idx     <= '0;
          state      <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (uart.i_tx_done) begin
            if (tx_idx == 3'd4) begin
              state <= RECV;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              state  <= SEND;
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

  // Response byte select: result MSB first, then zero flag.
  always_comb begin
    tx_byte = 8'h00;
    case (tx_idx)
      3'd0: tx_byte = result_reg[31:24];
      3'd1: tx_byte = result_reg[23:16];
      3'd2: tx_byte = result_reg[15:8];
      3'd3: tx_byte = result_reg[7:0];
      3'd4: tx_byte = {7'b0, zero_reg};
      default: tx_byte = 8'h00;
    endcase
  end

  assign uart.o_tx_data =
    (state == SEND || state == WAIT_TX) ? tx_byte : 8'h00;
  assign uart.o_tx_start = (state == SEND);
  assign o_busy = (state != RECV);

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Randomised frame traffic against a frame-level model,
// plus directed frames with hand-computed responses.
module tb_alu_frame_sequencer;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_frame_sequencer_if u_if ();

  logic [31:0] data_a, data_b, alu_res;
  logic [4:0]  shamt;
  logic        flag;
  logic [5:0]  op;
  logic        alu_zero, busy, overrun, ferr;

  alu_frame_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .uart         (u_if),
    .o_data_a     (data_a),
    .o_data_b     (data_b),
    .o_alu_shamt  (shamt),
    .o_flag_shamt (flag),
    .o_op         (op),
    .i_alu_result (alu_res),
    .i_alu_zero   (alu_zero),
    .o_busy       (busy),
    .o_rx_overrun (overrun),
    .o_frame_error(ferr)
  );

  function automatic logic [31:0] alu_fn(
    input logic [31:0] a, input logic [31:0] b,
    input logic [5:0] o, input logic f,
    input logic [4:0] s);
    case (o)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h02: return f ? (b >> s) : (b >> a[4:0]);
      default: return a ^ ~b;
    endcase
  endfunction

  assign alu_res  = alu_fn(data_a, data_b, op, flag, shamt);
  assign alu_zero = (alu_res == 32'd0);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [39:0] act,
                     input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // frame-level model
  logic [31:0] m_a = 0, m_b = 0;
  logic [5:0]  m_op = 0;
  logic        m_flag = 0;
  logic [4:0]  m_sh = 0;
  logic        m_ovr = 0, m_ferr = 0, m_busy = 0;
  int          m_n = 0, m_idle = 0;
  logic [7:0]  m_q[$];
  logic [7:0]  got[$];
  int          cyc = 0, frame_cyc = 0;
  int          ferr_seen = 0;
  int          sent = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic put_byte(input logic [7:0] d, input int c0);
    logic [31:0] r;
    case (m_n)
      0: m_a[31:24] = d;
      1: m_a[23:16] = d;
      2: m_a[15:8]  = d;
      3: m_a[7:0]   = d;
      4: m_b[31:24] = d;
      5: m_b[23:16] = d;
      6: m_b[15:8]  = d;
      7: m_b[7:0]   = d;
      8: begin m_op = d[5:0]; m_flag = d[7]; end
      default: m_sh = d[4:0];
    endcase
    m_idle = 0;
    m_n++;
    if (m_n == 10) begin
      m_n = 0;
      r = alu_fn(m_a, m_b, m_op, m_flag, m_sh);
      m_q.push_back(r[31:24]);
      m_q.push_back(r[23:16]);
      m_q.push_back(r[15:8]);
      m_q.push_back(r[7:0]);
      m_q.push_back({7'b0, r == 32'd0});
      m_busy = 1;
      frame_cyc = c0;
    end
  endtask

  // one clock with optional byte; model follows the sampled edge
  task automatic step(input logic v, input logic [7:0] d);
    int c0;
    c0 = cyc;
    u_if.i_rx_valid = v;
    u_if.i_rx_data  = v ? d : 8'h00;
    @(posedge clk);
    #1;
    u_if.i_rx_valid = 1'b0;
    m_ferr = 0;
    if (v) begin
      if (m_busy) m_ovr = 1;
      else put_byte(d, c0);
    end else if (m_n > 0 && !m_busy) begin
      m_idle++;
      if (m_idle == TO) begin
        m_n = 0;
        m_idle = 0;
        m_ferr = 1;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [7:0] b8,
                            input logic [7:0] b9,
                            input int maxgap);
    logic [7:0] fr[10];
    fr[0] = a[31:24]; fr[1] = a[23:16];
    fr[2] = a[15:8];  fr[3] = a[7:0];
    fr[4] = b[31:24]; fr[5] = b[23:16];
    fr[6] = b[15:8];  fr[7] = b[7:0];
    fr[8] = b8;       fr[9] = b9;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, maxgap)) step(1'b0, 8'h00);
      step(1'b1, fr[i]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk({nm, "_done"}, {39'd0, m_busy}, 40'd0);
    chk({nm, "_qempty"}, m_q.size(), 40'd0);
  endtask

  task automatic chk_resp(input string nm, input int base,
                          input logic [39:0] exp);
    logic [39:0] pk;
    pk = 'x;
    if (got.size() == base + 5)
      pk = {got[base], got[base+1], got[base+2],
            got[base+3], got[base+4]};
    chk(nm, pk, exp);
  endtask

  // UART transmitter stand-in plus per-cycle output compare
  initial begin
    logic       inflight;
    logic [7:0] held, e;
    int         wait_n;
    inflight = 0;
    held = 0;
    wait_n = 0;
    u_if.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_if.i_tx_done = 1'b0;
        inflight = 0;
        sent = 0;
      end else begin
        if (u_if.i_tx_done) begin
          u_if.i_tx_done = 1'b0;
          if (sent == 5) begin
            sent = 0;
            m_busy = 0;
          end
        end
        if (u_if.o_tx_start) begin
          if (sent == 0)
            chk("latency", cyc - frame_cyc, 40'd2);
          chk("tx_expected", {39'd0, m_q.size() != 0}, 40'd1);
          e = (m_q.size() != 0) ? m_q.pop_front() : 8'hxx;
          chk("tx_byte", u_if.o_tx_data, e);
          got.push_back(u_if.o_tx_data);
          held = u_if.o_tx_data;
          inflight = 1;
          wait_n = $urandom_range(0, 3);
        end else if (inflight) begin
          chk("tx_hold", u_if.o_tx_data, held);
          if (wait_n == 0) begin
            u_if.i_tx_done = 1'b1;
            inflight = 0;
            sent++;
          end else begin
            wait_n--;
          end
        end
        chk("data_a", data_a, m_a);
        chk("data_b", data_b, m_b);
        chk("op", op, m_op);
        chk("flag", flag, m_flag);
        chk("shamt", shamt, m_sh);
        chk("overrun", overrun, m_ovr);
        chk("frame_err", ferr, m_ferr);
        chk("busy", busy, m_busy);
        if (!m_busy) begin
          chk("idle_txd", u_if.o_tx_data, 40'd0);
          chk("idle_start", u_if.o_tx_start, 40'd0);
        end
        if (ferr) ferr_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, data_a, 40'd0);
    chk({nm, "_b"}, data_b, 40'd0);
    chk({nm, "_op"}, {flag, op, shamt}, 40'd0);
    chk({nm, "_tx"}, {u_if.o_tx_start, u_if.o_tx_data},
        40'd0);
    chk({nm, "_st"}, {busy, overrun, ferr}, 40'd0);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [31:0] a, b;
    logic [7:0] b8, b9;
    int base, f0, n;
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24;
    ops[3] = 6'h25; ops[4] = 6'h26; ops[5] = 6'h02;
    u_if.i_rx_valid = 1'b0;
    u_if.i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // 1: 2 + 1
    base = got.size();
    send_frame(32'd2, 32'd1, 8'h20, 8'h00, 0);
    wait_idle("t1");
    chk_resp("t1_resp", base, 40'h00_00_00_03_00);
    chk("t1_a", data_a, 40'd2);
    chk("t1_b", data_b, 40'd1);
    chk("t1_op", op, 40'h20);
    chk("t1_busy", busy, 40'd0);

    // 2: 5 - 5 sets zero
    base = got.size();
    send_frame(32'd5, 32'd5, 8'h22, 8'h00, 2);
    wait_idle("t2");
    chk_resp("t2_resp", base, 40'h00_00_00_00_01);
    chk("t2_op", op, 40'h22);

    // 3: field extraction from b8/b9
    send_frame($urandom, $urandom, 8'h82, 8'h1F, 1);
    wait_idle("t3");
    chk("t3_op", op, 40'h02);
    chk("t3_flag", flag, 40'd1);
    chk("t3_shamt", shamt, 40'h1F);

    // 4: partial frame times out, then a full frame
    f0 = ferr_seen;
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC);
    for (int i = 0; i < TO + 3; i++) step(1'b0, 8'h00);
    chk("t4_pulses", ferr_seen - f0, 40'd1);
    chk("t4_partial_a", data_a[31:8], 40'hAABBCC);
    base = got.size();
    send_frame(32'h10, 32'h20, 8'h20, 8'h00, 0);
    wait_idle("t4");
    chk_resp("t4_resp", base, 40'h00_00_00_30_00);

    // 5: byte during response is dropped, overrun sticks
    send_frame(32'h1234, 32'h0F0F, 8'h25, 8'h00, 0);
    repeat (4) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    wait_idle("t5");
    chk("t5_ovr", overrun, 40'd1);
    send_frame(32'd9, 32'd4, 8'h22, 8'h00, 1);
    wait_idle("t5b");
    chk("t5_ovr_sticky", overrun, 40'd1);

    // 6: reset mid-response
    send_frame(32'd1, 32'd2, 8'h20, 8'h00, 0);
    n = 0;
    while (sent < 2 && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("t6_reach", {39'd0, sent >= 2}, 40'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_a = 0; m_b = 0; m_op = 0; m_flag = 0; m_sh = 0;
    m_ovr = 0; m_ferr = 0; m_busy = 0;
    m_n = 0; m_idle = 0;
    m_q.delete();
    chk_zero("t6_rst");
    rst_n = 1'b1;
    base = got.size();
    send_frame(32'd7, 32'd7, 8'h22, 8'h00, 0);
    wait_idle("t6");
    chk_resp("t6_resp", base, 40'h00_00_00_00_01);

    // random frames
    for (int f = 0; f < 20; f++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      b8 = 8'($urandom);
      b8[5:0] = ops[$urandom_range(0, 5)];
      b9 = 8'($urandom);
      send_frame(a, b, b8, b9, 3);
      wait_idle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
